// File: rtl/cmp_pkg.sv
// Shared definitions for the CMP run monitor: NOP encoding, FSM states and default widths.
package cmp_pkg;

    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam int unsigned DEF_INST_W = 32;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 64;

    typedef enum logic [2:0] {
        StRun   = 3'd0,
        StFlush = 3'd1,
        StRd    = 3'd2,
        StWait  = 3'd3,
        StHold  = 3'd4,
        StDone  = 3'd5
    } cmp_state_e;

    // Index width that stays legal (>= 1) for a single-entry range.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_run_monitor_if.sv
// DMEM read port and dump stream shared between the run monitor and its neighbours.
interface cmp_run_monitor_if
    import cmp_pkg::*;
#(
    parameter int unsigned NUM_NODES = 4,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W
);

    localparam int unsigned NODE_W = idx_w(NUM_NODES);

    logic              dmem_rd_en;
    logic [NODE_W-1:0] dmem_node_sel;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_rd_data;

    logic              dump_valid;
    logic              dump_ready;
    logic [NODE_W-1:0] dump_node;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (
        output dmem_rd_en, dmem_node_sel, dmem_addr,
        input  dmem_rd_data,
        output dump_valid, dump_node, dump_addr, dump_data,
        input  dump_ready
    );

    modport slave (
        input  dmem_rd_en, dmem_node_sel, dmem_addr,
        output dmem_rd_data,
        input  dump_valid, dump_node, dump_addr, dump_data,
        output dump_ready
    );

endinterface

// File: rtl/cmp_done_detect.sv
// Program-completion detector: per-node NOP compare, optional sticky flags, AND-reduce.
module cmp_done_detect
    import cmp_pkg::*;
#(
    parameter int unsigned NUM_NODES   = 4,
    parameter int unsigned INST_W      = DEF_INST_W,
    parameter bit          STICKY_DONE = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [NUM_NODES*INST_W-1:0] node_inst_in,
    output logic                        all_nop
);

    logic [NUM_NODES-1:0] nop_now;

    always_comb begin
        nop_now = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            nop_now[i] = (node_inst_in[i*INST_W +: INST_W] == INST_W'(NOP_INST));
        end
    end

    if (STICKY_DONE) begin : g_sticky
        logic [NUM_NODES-1:0] seen_q;
        logic [NUM_NODES-1:0] seen_d;

        always_comb begin
            seen_d = seen_q;
            if (en) begin
                seen_d = seen_q | nop_now;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                seen_q <= '0;
            end else begin
                seen_q <= seen_d;
            end
        end

        // Flags raised this cycle already count towards completion.
        assign all_nop = en & (&(seen_q | nop_now));
    end else begin : g_same_cycle
        assign all_nop = en & (&nop_now);
    end

endmodule

// File: rtl/cmp_run_monitor.sv
// Run-control and DMEM dump sequencer: cycle counting, completion/watchdog detection,
// flush delay, then a node-by-node DMEM readout as a valid/ready stream.
module cmp_run_monitor
    import cmp_pkg::*;
#(
    parameter int unsigned NUM_NODES      = 4,
    parameter int unsigned INST_W         = DEF_INST_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned DUMP_DEPTH     = 128,
    parameter int unsigned FLUSH_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 12500,
    parameter int unsigned CNT_W          = 32,
    parameter bit          STICKY_DONE    = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_NODES*INST_W-1:0] node_inst_in,
    cmp_run_monitor_if.master           bus,
    output logic [CNT_W-1:0]            cycle_count,
    output logic                        run_done,
    output logic                        timed_out,
    output logic                        dump_done
);

    localparam int unsigned NODE_W  = idx_w(NUM_NODES);
    localparam int unsigned FLUSH_W = idx_w(FLUSH_CYCLES);

    localparam logic [NODE_W-1:0]  LAST_NODE  = NODE_W'(NUM_NODES - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DUMP_DEPTH - 1);
    localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    cmp_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               run_done_q, run_done_d;
    logic               timed_out_q, timed_out_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic [NODE_W-1:0]  node_q, node_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;
    logic [NODE_W-1:0]  hold_node_q, hold_node_d;
    logic [ADDR_W-1:0]  hold_addr_q, hold_addr_d;

    logic run_en;
    logic all_nop;

    assign run_en = (state_q == StRun);

    cmp_done_detect #(
        .NUM_NODES   (NUM_NODES),
        .INST_W      (INST_W),
        .STICKY_DONE (STICKY_DONE)
    ) u_done_detect (
        .clk          (clk),
        .reset        (reset),
        .en           (run_en),
        .node_inst_in (node_inst_in),
        .all_nop      (all_nop)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        run_done_d  = run_done_q;
        timed_out_d = timed_out_q;
        flush_d     = flush_q;
        node_d      = node_q;
        addr_d      = addr_q;
        hold_data_d = hold_data_q;
        hold_node_d = hold_node_q;
        hold_addr_d = hold_addr_q;

        unique case (state_q)
            StRun: begin
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
                flush_d = '0;
                node_d  = '0;
                addr_d  = '0;
                // Completion wins over a watchdog expiring in the same cycle.
                if (all_nop) begin
                    run_done_d = 1'b1;
                    state_d    = StFlush;
                end else if (count_q == TMO_LAST) begin
                    timed_out_d = 1'b1;
                    state_d     = StFlush;
                end
            end
            StFlush: begin
                node_d = '0;
                addr_d = '0;
                if (flush_q == LAST_FLUSH) begin
                    state_d = StRd;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            StRd: begin
                state_d = StWait;
            end
            StWait: begin
                hold_data_d = bus.dmem_rd_data;
                hold_node_d = node_q;
                hold_addr_d = addr_q;
                state_d     = StHold;
            end
            StHold: begin
                if (bus.dump_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        if (node_q == LAST_NODE) begin
                            state_d = StDone;
                        end else begin
                            node_d  = node_q + 1'b1;
                            state_d = StRd;
                        end
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StRd;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StRun;
            count_q     <= '0;
            run_done_q  <= 1'b0;
            timed_out_q <= 1'b0;
            flush_q     <= '0;
            node_q      <= '0;
            addr_q      <= '0;
            hold_data_q <= '0;
            hold_node_q <= '0;
            hold_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            run_done_q  <= run_done_d;
            timed_out_q <= timed_out_d;
            flush_q     <= flush_d;
            node_q      <= node_d;
            addr_q      <= addr_d;
            hold_data_q <= hold_data_d;
            hold_node_q <= hold_node_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    assign bus.dmem_rd_en    = (state_q == StRd);
    assign bus.dmem_node_sel = node_q;
    assign bus.dmem_addr     = addr_q;
    assign bus.dump_valid    = (state_q == StHold);
    assign bus.dump_node     = hold_node_q;
    assign bus.dump_addr     = hold_addr_q;
    assign bus.dump_data     = hold_data_q;

    assign cycle_count = count_q;
    assign run_done    = run_done_q;
    assign timed_out   = timed_out_q;
    assign dump_done   = (state_q == StDone);

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Directed bench for cmp_run_monitor: run/timeout table, full dumps, stalls and mid-dump reset.
module tb_cmp_run_monitor;

    localparam int unsigned TMO   = 300;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned TOTAL = 4 * DEPTH;
    localparam int          NV    = 8;

    typedef struct {
        int mode;      // 0: all NOP at cyc, 1: node i NOP at cyc+i, 2: never
        int cyc;
        int exp_done;
        int exp_to;
        int exp_cnt;
        int exp_s_done;
        int exp_s_to;
        int exp_s_cnt;
    } run_vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [127:0] node_inst = '1;
    logic [31:0]  cycle_count, s_cycle_count;
    logic         run_done, timed_out, dump_done;
    logic         s_run_done, s_timed_out, s_dump_done;
    int           rd_cnt = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    run_vec_t     vecs[NV];

    always #5 clk = ~clk;

    cmp_run_monitor_if #(.NUM_NODES(4), .ADDR_W(8), .DATA_W(64)) bus ();
    cmp_run_monitor_if #(.NUM_NODES(4), .ADDR_W(8), .DATA_W(64)) bus_s ();

    cmp_run_monitor #(
        .DUMP_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .STICKY_DONE    (1'b0)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .node_inst_in (node_inst),
        .bus          (bus),
        .cycle_count  (cycle_count),
        .run_done     (run_done),
        .timed_out    (timed_out),
        .dump_done    (dump_done)
    );

    cmp_run_monitor #(
        .DUMP_DEPTH     (2),
        .TIMEOUT_CYCLES (TMO),
        .STICKY_DONE    (1'b1)
    ) u_dut_sticky (
        .clk          (clk),
        .reset        (reset),
        .node_inst_in (node_inst),
        .bus          (bus_s),
        .cycle_count  (s_cycle_count),
        .run_done     (s_run_done),
        .timed_out    (s_timed_out),
        .dump_done    (s_dump_done)
    );

    assign bus_s.dump_ready   = 1'b1;
    assign bus_s.dmem_rd_data = '0;

    function automatic logic [63:0] mk_word(input int n, input int a);
        return {16'hC0DE, 8'(n), 8'h5A, 16'h0000, 8'(a), ~8'(a)};
    endfunction

    // DMEM model: one-cycle read latency, garbage when not strobed.
    always @(posedge clk) begin
        if (bus.dmem_rd_en) begin
            bus.dmem_rd_data <= mk_word(int'(bus.dmem_node_sel), int'(bus.dmem_addr));
            rd_cnt           <= rd_cnt + 1;
        end else begin
            bus.dmem_rd_data <= 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] inst_for(input run_vec_t t, input int k, input int i);
        logic nop;
        case (t.mode)
            0:       nop = (k == t.cyc);
            1:       nop = (k == t.cyc + i);
            default: nop = 1'b0;
        endcase
        return nop ? 32'h0 : (32'h1 << ((k + i) % 32));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        node_inst      = '1;
        bus.dump_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, bus.dmem_rd_en, 0);
        check({tag, "_node_sel"}, bus.dmem_node_sel, 0);
        check({tag, "_dmem_addr"}, bus.dmem_addr, 0);
        check({tag, "_dump_valid"}, bus.dump_valid, 0);
        check({tag, "_dump_node"}, bus.dump_node, 0);
        check({tag, "_dump_addr"}, bus.dump_addr, 0);
        check({tag, "_dump_data"}, bus.dump_data, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_run_done"}, run_done, 0);
        check({tag, "_timed_out"}, timed_out, 0);
        check({tag, "_dump_done"}, dump_done, 0);
    endtask

    // Completes a run at cycle 1, then consumes the dump with the given ready probability.
    // With stop_node >= 0 it returns at the negedge where that node/addr word is valid.
    task automatic run_dump(input int pct, input int stop_node, input int stop_addr,
                            input string tag);
        int          idx, cyc, last_acc, bad_order, bad_stab, bad_gap, rd0, done_early;
        logic        pv, pr, rdy, stopped;
        logic [1:0]  pn;
        logic [7:0]  pa;
        logic [63:0] pd;
        idx = 0; cyc = 0; last_acc = -1; bad_order = 0; bad_stab = 0; bad_gap = 0;
        done_early = 0; pv = 0; pr = 0; pn = '0; pa = '0; pd = '0; stopped = 0;
        do_reset();
        rd0       = rd_cnt;
        node_inst = '0;
        @(posedge clk);
        @(negedge clk);
        node_inst = '1;
        while (!stopped && idx < TOTAL && cyc < 20000) begin
            if (stop_node >= 0 && bus.dump_valid && int'(bus.dump_node) == stop_node &&
                int'(bus.dump_addr) == stop_addr) begin
                stopped = 1;
            end else begin
                rdy            = ($urandom_range(0, 99) < pct);
                bus.dump_ready = rdy;
                if (pv && !pr) begin
                    if (!bus.dump_valid || bus.dump_node !== pn || bus.dump_addr !== pa ||
                        bus.dump_data !== pd) bad_stab++;
                end
                if (bus.dump_valid && rdy) begin
                    if (int'(bus.dump_node) != idx / DEPTH ||
                        int'(bus.dump_addr) != idx % DEPTH ||
                        bus.dump_data !== mk_word(idx / DEPTH, idx % DEPTH)) bad_order++;
                    if (last_acc >= 0 && cyc - last_acc != 3) bad_gap++;
                    if (dump_done) done_early++;
                    last_acc = cyc;
                    idx++;
                end
                pv = bus.dump_valid; pr = rdy;
                pn = bus.dump_node; pa = bus.dump_addr; pd = bus.dump_data;
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_order_errs"}, bad_order, 0);
        check({tag, "_stable_errs"}, bad_stab, 0);
        if (stop_node < 0) begin
            check({tag, "_words"}, idx, TOTAL);
            check({tag, "_rd_pulses"}, rd_cnt - rd0, TOTAL);
            check({tag, "_done_before_last"}, done_early, 0);
            check({tag, "_dump_done"}, dump_done, 1);
            check({tag, "_valid_after_done"}, bus.dump_valid, 0);
            if (pct == 100) check({tag, "_gap_errs"}, bad_gap, 0);
            repeat (4) @(posedge clk);
            #1;
            check({tag, "_done_held"}, {dump_done, bus.dmem_rd_en, bus.dump_valid}, 3'b100);
        end else begin
            check({tag, "_reached_stop"}, stopped, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f_main, f_s, f_rd;
        vecs[0] = '{0, 20, 1, 0, 20, 1, 0, 20};
        vecs[1] = '{0, 1, 1, 0, 1, 1, 0, 1};
        vecs[2] = '{1, 10, 0, 1, TMO, 1, 0, 13};
        vecs[3] = '{0, TMO, 1, 0, TMO, 1, 0, TMO};
        vecs[4] = '{0, TMO + 1, 0, 1, TMO, 0, 1, TMO};
        vecs[5] = '{1, TMO - 2, 0, 1, TMO, 0, 1, TMO};
        vecs[6] = '{1, TMO - 3, 0, 1, TMO, 1, 0, TMO};
        vecs[7] = '{2, 0, 0, 1, TMO, 0, 1, TMO};

        bus.dump_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");

        for (int v = 0; v < NV; v++) begin
            f_main = -1; f_s = -1; f_rd = -1;
            do_reset();
            bus.dump_ready = 1'b1;
            for (int k = 1; k <= int'(TMO) + 8; k++) begin
                for (int i = 0; i < 4; i++) node_inst[i*32 +: 32] = inst_for(vecs[v], k, i);
                @(posedge clk);
                #1;
                if (f_main < 0 && (run_done || timed_out)) f_main = k;
                if (f_s < 0 && (s_run_done || s_timed_out)) f_s = k;
                if (f_rd < 0 && bus.dmem_rd_en) f_rd = k;
                @(negedge clk);
            end
            check($sformatf("v%0d_run_done", v), run_done, vecs[v].exp_done);
            check($sformatf("v%0d_timed_out", v), timed_out, vecs[v].exp_to);
            check($sformatf("v%0d_cycle_count", v), cycle_count, vecs[v].exp_cnt);
            check($sformatf("v%0d_end_cycle", v), f_main, vecs[v].exp_cnt);
            check($sformatf("v%0d_first_rd", v), f_rd, vecs[v].exp_cnt + 5);
            check($sformatf("v%0d_s_run_done", v), s_run_done, vecs[v].exp_s_done);
            check($sformatf("v%0d_s_timed_out", v), s_timed_out, vecs[v].exp_s_to);
            check($sformatf("v%0d_s_cycle_count", v), s_cycle_count, vecs[v].exp_s_cnt);
            check($sformatf("v%0d_s_end_cycle", v), f_s, vecs[v].exp_s_cnt);
        end

        run_dump(100, -1, 0, "dump_full");
        run_dump(30, -1, 0, "dump_stall");

        run_dump(100, 2, 5, "dump_abort");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        reset     = 1'b1;
        node_inst = '1;
        repeat (3) @(posedge clk);
        #1;
        check("restart_count", cycle_count, 3);
        check("restart_flags", {run_done, timed_out, bus.dump_valid, bus.dmem_rd_en}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
